// File: rtl/fp_mul_normalize_round.sv
// Normalize/round/pack stage of the binary32 multiplier; FP_MUL_ROUND_MODES_EN adds directed rounding via rnd_mode.
// Latency 2 cycles, 1 beat/cycle; valid/ready at both ends, stalls propagate back through in_ready.
module fp_mul_normalize_round #(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
`ifdef FP_MUL_ROUND_MODES_EN
    input  logic [1:0]       rnd_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact,
    output logic             out_invalid
);
    // Two spare bits keep ea+eb-127 plus both increments from wrapping.
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] L_EXP_OVF  = XW'(255);
    localparam logic signed [XW-1:0] L_EXP_ZERO = '0;

    logic                 r_s1_vld, r_s1_sign, r_s1_grd, r_s1_stk;
    logic                 r_s1_zero, r_s1_inf, r_s1_nan;
    logic signed [XW-1:0] r_s1_exp;
    logic [23:0]          r_s1_sig;
`ifdef FP_MUL_ROUND_MODES_EN
    logic [1:0]           r_s1_mode;
`endif
    logic                 r_s2_vld, r_ovf, r_udf, r_inx, r_inv;
    logic [31:0]          r_res;

    logic                 w_s2_free, w_s1_adv, w_in_acc;
    logic signed [XW-1:0] w_in_exp_x, w_n_exp, w_exp2;
    logic [23:0]          w_n_sig;
    logic                 w_n_grd, w_n_stk;
    logic                 w_round_up, w_ovf_max;
    logic [24:0]          w_sum;
    logic [22:0]          w_frac;
    logic [31:0]          w_res;
    logic                 w_ovf, w_udf, w_inx, w_inv;

    assign w_s2_free = !r_s2_vld | out_ready;
    assign w_s1_adv  = r_s1_vld & w_s2_free;
    assign in_ready  = !r_s1_vld | w_s2_free;
    assign w_in_acc  = in_valid & in_ready;

    assign w_in_exp_x = {{2{in_exp[EXP_W-1]}}, in_exp};
    assign w_n_exp    = w_in_exp_x + {{(XW-1){1'b0}}, in_mant[47]};
    assign w_n_sig    = in_mant[47] ? in_mant[47:24] : in_mant[46:23];
    assign w_n_grd    = in_mant[47] ? in_mant[23]    : in_mant[22];
    assign w_n_stk    = in_mant[47] ? |in_mant[22:0] : |in_mant[21:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_sig  <= '0;
            r_s1_grd  <= 1'b0;
            r_s1_stk  <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_nan  <= 1'b0;
`ifdef FP_MUL_ROUND_MODES_EN
            r_s1_mode <= 2'b00;
`endif
        end else begin
            if (in_ready) r_s1_vld <= in_valid;
            if (w_in_acc) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_n_exp;
                r_s1_sig  <= w_n_sig;
                r_s1_grd  <= w_n_grd;
                r_s1_stk  <= w_n_stk;
                r_s1_zero <= in_zero;
                r_s1_inf  <= in_inf;
                r_s1_nan  <= in_nan;
`ifdef FP_MUL_ROUND_MODES_EN
                r_s1_mode <= rnd_mode;
`endif
            end
        end
    end

`ifdef FP_MUL_ROUND_MODES_EN
    always_comb begin
        w_round_up = 1'b0;
        w_ovf_max  = 1'b0;
        case (r_s1_mode)
            2'b00: w_round_up = r_s1_grd & (r_s1_stk | r_s1_sig[0]);
            2'b01: w_ovf_max  = 1'b1;
            2'b10: begin
                w_round_up = (r_s1_grd | r_s1_stk) & !r_s1_sign;
                w_ovf_max  = r_s1_sign;
            end
            default: begin
                w_round_up = (r_s1_grd | r_s1_stk) & r_s1_sign;
                w_ovf_max  = !r_s1_sign;
            end
        endcase
    end
`else
    assign w_round_up = r_s1_grd & (r_s1_stk | r_s1_sig[0]);
    assign w_ovf_max  = 1'b0;
`endif

    // On carry-out the significand is 1.0 x 2: shift right one and bump the exponent.
    assign w_sum  = {1'b0, r_s1_sig} + {24'h0, w_round_up};
    assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_exp2 = r_s1_exp + {{(XW-1){1'b0}}, w_sum[24]};

    always_comb begin
        w_res = {r_s1_sign, w_exp2[7:0], w_frac};
        w_ovf = 1'b0;
        w_udf = 1'b0;
        w_inx = r_s1_grd | r_s1_stk;
        w_inv = 1'b0;
        if (w_exp2 >= L_EXP_OVF) begin
            w_res = w_ovf_max ? {r_s1_sign, 8'hFE, 23'h7FFFFF} : {r_s1_sign, 8'hFF, 23'h0};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_exp2 <= L_EXP_ZERO) begin
            w_res = {r_s1_sign, 31'h0};
            w_udf = 1'b1;
            w_inx = 1'b1;
        end
        if (r_s1_nan | (r_s1_inf & r_s1_zero) | r_s1_inf | r_s1_zero) begin
            w_ovf = 1'b0;
            w_udf = 1'b0;
            w_inx = 1'b0;
            if (r_s1_nan | (r_s1_inf & r_s1_zero)) begin
                w_res = QNAN;
                w_inv = 1'b1;
            end else if (r_s1_inf) begin
                w_res = {r_s1_sign, 8'hFF, 23'h0};
            end else begin
                w_res = {r_s1_sign, 31'h0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_inx    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            if (w_s2_free) r_s2_vld <= r_s1_vld;
            if (w_s1_adv) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
                r_udf <= w_udf;
                r_inx <= w_inx;
                r_inv <= w_inv;
            end
        end
    end

    assign out_valid     = r_s2_vld;
    assign out_result    = r_res;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_udf;
    assign out_inexact   = r_inx;
    assign out_invalid   = r_inv;
endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Bench for fp_mul_normalize_round: directed vector table, backpressure/reset sequences, and a
// randomized stream scored against a value-level rounding model.
module tb_fp_mul_normalize_round;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sign, in_zero, in_inf, in_nan;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact, out_invalid;
    logic [31:0] out_result;

    int n_cmp = 0;
    int n_err = 0;
    int n_dlv = 0;
    int rdy_mode = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;   // {overflow, underflow, inexact, invalid}
    } res_t;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        logic        z;
        logic        i;
        logic        n;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    res_t q[$];
    vec_t vt[14];

    fp_mul_normalize_round dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_inexact(out_inexact), .out_invalid(out_invalid)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Rounding by value: remainder against exactly half an ulp, ties to even.
    function automatic res_t model(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                                   input logic z, input logic inf, input logic nan);
        res_t r;
        longint unsigned mm, sig, rem, half;
        int sh, ex;
        r = '0;
        if (nan || (inf && z)) begin r.res = 32'h7FC00000; r.flg = 4'b0001; return r; end
        if (inf) begin r.res = {s, 8'hFF, 23'h0}; return r; end
        if (z) begin r.res = {s, 31'h0}; return r; end
        mm   = 64'(m);
        sh   = m[47] ? 24 : 23;
        ex   = int'(e) + sh - 23;
        sig  = mm >> sh;
        rem  = mm - (sig << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin sig = sig >> 1; ex = ex + 1; end
        if (ex >= 255) begin
            r.res = {s, 8'hFF, 23'h0}; r.flg = 4'b1010;
        end else if (ex <= 0) begin
            r.res = {s, 31'h0}; r.flg = 4'b0110;
        end else begin
            r.res = {s, 8'(ex), 23'(sig)};
            r.flg = {2'b00, (rem != 0), 1'b0};
        end
        return r;
    endfunction

    // Scoreboard: predict on accept, compare in order on delivery.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) q.delete();
            else begin
                if (out_valid && out_ready) begin
                    n_dlv++;
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_extra: got %h expected no beat", out_result);
                    end else begin
                        e = q.pop_front();
                        chk("sb_out", 64'({out_result, out_overflow, out_underflow, out_inexact, out_invalid}),
                            64'(e));
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(model(in_sign, in_exp, in_mant, in_zero, in_inf, in_nan));
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic z, input logic i, input logic n);
        logic ok;
        in_sign = s; in_exp = e; in_mant = m; in_zero = z; in_inf = i; in_nan = n;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected accept within 50 cycles");
        end
    endtask

    initial begin
        int lat, cnt, d0;
        logic [47:0] m;
        longint unsigned a, b;
        logic [9:0] ev;

        vt[0]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h40100000, 4'b0000};
        vt[1]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0010};
        vt[2]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F800002, 4'b0010};
        vt[3]  = '{1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h40000000, 4'b0010};
        vt[4]  = '{1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hFF800000, 4'b1010};
        vt[5]  = '{1'b0, 10'h3F0, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0110};
        vt[6]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 4'b0001};
        vt[7]  = '{1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF800000, 4'b0000};
        vt[8]  = '{1'b1, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h80000000, 4'b0000};
        vt[9]  = '{1'b0, 10'd5,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 4'b0001};
        vt[10] = '{1'b0, 10'd254, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F000000, 4'b0000};
        vt[11] = '{1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b1010};
        vt[12] = '{1'b0, 10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h00800000, 4'b0000};
        vt[13] = '{1'b0, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0110};

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_result", 64'({out_result, out_overflow, out_underflow, out_inexact, out_invalid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed table, one beat at a time with latency check.
        for (int i = 0; i < 14; i++) begin
            send(vt[i].s, vt[i].e, vt[i].m, vt[i].z, vt[i].i, vt[i].n);
            in_valid = 1'b0;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = k;
                    chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(vt[i].res));
                    chk($sformatf("vec%0d_flags", i),
                        64'({out_overflow, out_underflow, out_inexact, out_invalid}), 64'(vt[i].flg));
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
        end

        // Backpressure: four beats, out_ready low for three cycles.
        d0 = n_dlv;
        out_ready = 1'b0;
        send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        send(1'b1, 10'd130, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0);
        in_sign = 1'b0; in_exp = 10'd100; in_mant = 48'h7FFF_FFFF_FFFF; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b0, 10'd100, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(1'b1, 10'd3,   48'h5555_5555_5555, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_delivered", 64'(n_dlv - d0), 64'd4);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Randomized stream with random backpressure.
        rdy_mode = 1;
        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            a = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            b = longint'($urandom_range(24'hFFFFFF, 24'h800000));
            m = 48'(a * b);
            case ($urandom_range(0, 3))
                0:       ev = 10'($signed($urandom_range(12, 0)) - 6);
                1:       ev = 10'($urandom_range(262, 248));
                default: ev = 10'($urandom_range(200, 50));
            endcase
            if ($urandom_range(0, 15) == 0)
                send($urandom_range(0, 1) == 1, ev, m, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            else
                send($urandom_range(0, 1) == 1, ev, m, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        // Reset asserted mid-stream discards in-flight beats.
        send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        send(1'b0, 10'd128, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        send(1'b0, 10'd129, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst_no_emit", 64'(cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_mul_normalize_round.md
Name: fp_mul_normalize_round

Overview:
- Downstream stage of the single-precision floating-point multiplier datapath.
- Consumes the 48-bit raw mantissa product (24x24 with hidden bits), the pre-biased exponent sum, the sign and the special-case flags.
- Normalizes, rounds and detects overflow/underflow, then packs an IEEE-754 binary32 result.
- Two-stage pipeline with valid/ready handshake at both ends.

Parameters:
- EXP_W, 10: width of the signed biased exponent input (two's complement; holds ea+eb-127).
- QNAN, 32'h7FC00000: canonical NaN emitted for invalid or NaN operands.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_sign  in  1  product sign (sa^sb)
- in_exp  in  EXP_W  signed biased exponent ea+eb-127
- in_mant  in  48  raw mantissa product, value in [1,4) for normal operands
- in_zero  in  1  an operand is zero
- in_inf  in  1  an operand is infinity
- in_nan  in  1  an operand is NaN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  packed binary32 result
- out_overflow  out  1  result overflowed to infinity
- out_underflow  out  1  result flushed to zero
- out_inexact  out  1  rounding discarded nonzero bits
- out_invalid  out  1  inf*0 or NaN operand

Behaviour:
- Reset: all stage valid bits 0; out_valid=0; out_result=0; all flags 0. Asserting rst_n low mid-operation discards in-flight beats immediately. The first accept is possible on the first clock edge after deassertion.
- Transfer rules: a beat is accepted when in_valid & in_ready, and delivered when out_valid & out_ready.
- Handshake and stalls:
  - Stage k advances when its successor is empty or advancing; in_ready = !s1_valid | s1_advance.
  - Fill and drain proceed concurrently in the same cycle.
  - Outputs hold stable while out_valid & !out_ready.
- Latency: 2 cycles from accept to out_valid with out_ready high; throughput 1 beat/cycle; order preserved.
- Stage 1, normalize:
  - If in_mant[47]: sig=in_mant[47:24], guard=in_mant[23], sticky=|in_mant[22:0], exp=in_exp+1.
  - Else: sig=in_mant[46:23], guard=in_mant[22], sticky=|in_mant[21:0], exp=in_exp.
  - Sign and special flags are registered alongside.
- Stage 2, round and pack:
  - Round-to-nearest-even: round_up = guard & (sticky | sig[0]); 25-bit sum = sig + round_up.
  - If sum[24] (carry-out): fraction=0, exp+1.
  - inexact = guard | sticky.
- Range checks on the final signed exp:
  - exp >= 255: result {sign,8'hFF,23'h0}, overflow=1, inexact=1.
  - exp <= 0: no subnormal outputs; result {sign,31'h0}, underflow=1, inexact=1.
  - Otherwise result {sign, exp[7:0], sum[22:0]}.
- Special-case priority (overrides all arithmetic; flags overflow/underflow/inexact=0):
  1. in_nan, or in_inf & in_zero: QNAN, invalid=1.
  2. in_inf: {sign,8'hFF,0}.
  3. in_zero: {sign,31'h0}.
- Flags are registered with out_result and valid only while out_valid=1.

Optional Feature:
- Macro: FP_MUL_ROUND_MODES_EN
- With the macro defined:
  - Adds input port rnd_mode[1:0], sampled with in_valid and carried down the pipeline.
  - Modes: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
  - Directed-mode round_up = (guard|sticky) & (sign != direction).
  - Overflow under RTZ, or when rounding away from the sign's direction, yields max finite {sign,8'hFE,23'h7FFFFF} with overflow=1.
- Without the macro: rnd_mode port absent; RNE only.

Test Plan:
- Product 1.5*1.5: in_exp=127, in_mant=48'h9000_0000_0000, sign=0 -> out_result=32'h40100000, no flags, out_valid exactly 2 cycles after accept.
- Tie handling with sign=0, in_exp=127:
  - in_mant=48'h4000_0040_0000 -> 32'h3F800000, inexact=1.
  - in_mant=48'h4000_00C0_0000 -> 32'h3F800002, inexact=1.
  - in_mant=48'h7FFF_FFFF_FFFF -> carry-out, 32'h40000000.
- Overflow: in_exp=254, in_mant=48'h8000_0000_0000, sign=1 -> 32'hFF800000, overflow=1, inexact=1.
- Underflow: in_exp=10'h3F0 (-16), in_mant=48'h4000_0000_0000 -> 32'h00000000, underflow=1.
- Specials:
  - in_inf=1 with in_zero=1 -> 32'h7FC00000, invalid=1.
  - in_inf=1 alone with sign=1 -> 32'hFF800000, no flags.
- Backpressure and reset:
  - 4 back-to-back beats with out_ready low 3 cycles -> in_ready drops after 2 held beats; all 4 results delivered in order with no loss or duplication.
  - rst_n pulsed low mid-stream -> out_valid=0 asynchronously, nothing emitted afterwards.
